// File: rtl/if_id_buffer.sv
// Two-entry elastic buffer between instruction fetch and decode.
// Optional IFID_BUBBLE_COUNT_EN adds a saturating count of decode-side bubbles.
module if_id_buffer #(
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] pc_in,
  input  logic [DATA_W-1:0] pc_plus_1_in,
  input  logic [DATA_W-1:0] insn_in,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_pc,
  output logic [DATA_W-1:0] out_pc_plus_1,
  output logic [DATA_W-1:0] out_insn,
  output logic [4:0]        out_opcode,
  output logic [1:0]        count
`ifdef IFID_BUBBLE_COUNT_EN
  ,
  output logic [15:0]       bubble_count
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam int ENTRY_W = 3 * DATA_W;

  state_t             state;
  logic [ENTRY_W-1:0] mem [2];
  logic               rd_ptr;
  logic               wr_ptr;
  logic               enq;
  logic               deq;
  logic [ENTRY_W-1:0] head;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign enq = in_valid & in_ready;
  assign deq = out_valid & out_ready;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= EMPTY;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else if (flush) begin
      // Redirect wins over any handshake in the same cycle.
      state  <= EMPTY;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else begin
      if (enq) begin
        mem[wr_ptr] <= {pc_in, pc_plus_1_in, insn_in};
        wr_ptr      <= ~wr_ptr;
      end
      if (deq) begin
        rd_ptr <= ~rd_ptr;
      end
      case (state)
        EMPTY: if (enq) state <= ONE;
        ONE: begin
          if (enq && !deq)      state <= FULL;
          else if (deq && !enq) state <= EMPTY;
        end
        FULL:    if (deq) state <= ONE;
        default: state <= EMPTY;
      endcase
    end
  end

  assign count     = state;
  assign out_valid = (state != EMPTY);
  assign in_ready  = reset & (state != FULL);
  assign head      = mem[rd_ptr];

  // Empty head presents all-zero fields so decode sees a NOP.
  always_comb begin
    out_pc        = '0;
    out_pc_plus_1 = '0;
    out_insn      = '0;
    if (out_valid) begin
      out_pc        = head[ENTRY_W-1 -: DATA_W];
      out_pc_plus_1 = head[2*DATA_W-1 -: DATA_W];
      out_insn      = head[DATA_W-1:0];
    end
  end

  assign out_opcode = out_insn[DATA_W-1 -: 5];

`ifdef IFID_BUBBLE_COUNT_EN
  logic [15:0] bubble_cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bubble_cnt <= '0;
    end else if (out_ready && !out_valid && !flush) begin
      bubble_cnt <= sat_inc16(bubble_cnt);
    end
  end

  assign bubble_count = bubble_cnt;
`else
  // Default build: no bubble counter, the helper function is simply unused.
  logic unused_sat;
  assign unused_sat = ^sat_inc16(16'd0);
`endif

endmodule

// File: tb/tb_if_id_buffer.sv
// Directed bench for if_id_buffer: a queue model checked every cycle, plus literal pins.
// Define IFID_BUBBLE_COUNT_EN to also exercise the bubble counter.
module tb_if_id_buffer;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] pc_in = '0, pc_plus_1_in = '0, insn_in = '0;
  logic        in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
  logic        in_ready, out_valid;
  logic [31:0] out_pc, out_pc_plus_1, out_insn;
  logic [4:0]  out_opcode;
  logic [1:0]  count;
`ifdef IFID_BUBBLE_COUNT_EN
  logic [15:0] bubble_count;
`endif

  int tests = 0;
  int fails = 0;

  logic [95:0] q[$];

  if_id_buffer dut (
    .clock(clock), .reset(reset),
    .pc_in(pc_in), .pc_plus_1_in(pc_plus_1_in), .insn_in(insn_in),
    .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_pc_plus_1(out_pc_plus_1), .out_insn(out_insn),
    .out_opcode(out_opcode), .count(count)
`ifdef IFID_BUBBLE_COUNT_EN
    , .bubble_count(bubble_count)
`endif
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a FIFO of at most two beats; flush empties it, reset empties it at once.
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      q.delete();
    end else begin
      bit take, give;
      take = in_valid && (q.size() < 2);
      give = (q.size() > 0) && out_ready;
      if (flush) begin
        q.delete();
      end else begin
        if (give) void'(q.pop_front());
        if (take) q.push_back({pc_in, pc_plus_1_in, insn_in});
      end
    end
  end

  // Per-cycle comparison away from the active edge.
  always @(negedge clock) begin
    logic [95:0] h;
    h = (q.size() > 0) ? q[0] : 96'd0;
    chk("m_count",     {30'd0, count},     q.size());
    chk("m_out_valid", {31'd0, out_valid}, (q.size() > 0) ? 32'd1 : 32'd0);
    chk("m_in_ready",  {31'd0, in_ready},  (reset && q.size() < 2) ? 32'd1 : 32'd0);
    chk("m_out_pc",    out_pc,             h[95:64]);
    chk("m_out_pc4",   out_pc_plus_1,      h[63:32]);
    chk("m_out_insn",  out_insn,           h[31:0]);
    chk("m_opcode",    {27'd0, out_opcode}, {27'd0, h[31:27]});
  end

  // Drive one cycle of inputs, step past the edge, land 1ns after it.
  task automatic cyc(input logic iv, input logic [31:0] pc, input logic [31:0] insn,
                     input logic ordy, input logic fl);
    in_valid     = iv;
    pc_in        = pc;
    pc_plus_1_in = pc + 32'd4;
    insn_in      = insn;
    out_ready    = ordy;
    flush        = fl;
    @(posedge clock);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clock);
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_count",    {30'd0, count},    32'd0);
    chk("rst_out_pc",   out_pc,            32'd0);
    reset = 1'b1;

    // Single pass, accepted on the first edge after release.
    cyc(1'b1, 32'h0, 32'hA000_0001, 1'b1, 1'b0);
    chk("sp_valid",  {31'd0, out_valid},  32'd1);
    chk("sp_opcode", {27'd0, out_opcode}, 32'h14);
    chk("sp_pc4",    out_pc_plus_1,       32'h4);
    cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("sp_drain",  {30'd0, count},      32'd0);

    // Fill, then a third beat is ignored.
    cyc(1'b1, 32'h8, 32'h1111_0008, 1'b0, 1'b0);
    cyc(1'b1, 32'hC, 32'h2222_000C, 1'b0, 1'b0);
    chk("fill_count", {30'd0, count},    32'd2);
    chk("fill_ready", {31'd0, in_ready}, 32'd0);
    cyc(1'b1, 32'h10, 32'h3333_0010, 1'b0, 1'b0);
    chk("fill_hold",  {30'd0, count},    32'd2);
    chk("fill_head0", out_pc,            32'h8);
    cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("fill_head1", out_pc,            32'hC);
    cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("fill_empty", {31'd0, out_valid}, 32'd0);

    // Simultaneous enqueue and dequeue in ONE.
    cyc(1'b1, 32'h20, 32'h4444_0020, 1'b0, 1'b0);
    cyc(1'b1, 32'h24, 32'h5555_0024, 1'b1, 1'b0);
    chk("sim_count", {30'd0, count}, 32'd1);
    chk("sim_pc",    out_pc,         32'h24);
    cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Flush in FULL with a beat offered.
    cyc(1'b1, 32'h30, 32'h6666_0030, 1'b0, 1'b0);
    cyc(1'b1, 32'h34, 32'h7777_0034, 1'b0, 1'b0);
    cyc(1'b1, 32'h40, 32'h8888_0040, 1'b0, 1'b1);
    chk("fl_count", {30'd0, count},     32'd0);
    chk("fl_valid", {31'd0, out_valid}, 32'd0);
    chk("fl_insn",  out_insn,           32'd0);
    cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("fl_nostore", {30'd0, count},   32'd0);

    // Flush in ONE drops the concurrent enqueue and dequeue; order restarts at entry 0.
    cyc(1'b1, 32'h50, 32'h9999_0050, 1'b0, 1'b0);
    cyc(1'b1, 32'h54, 32'hAAAA_0054, 1'b1, 1'b1);
    chk("fl1_count", {30'd0, count}, 32'd0);
    cyc(1'b1, 32'h58, 32'hBBBB_0058, 1'b0, 1'b0);
    cyc(1'b1, 32'h5C, 32'hCCCC_005C, 1'b1, 1'b0);
    chk("fl1_order", out_pc, 32'h5C);
    cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Asynchronous reset with two beats buffered.
    cyc(1'b1, 32'h60, 32'hDDDD_0060, 1'b0, 1'b0);
    cyc(1'b1, 32'h64, 32'hEEEE_0064, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    chk("ar_valid", {31'd0, out_valid}, 32'd0);
    chk("ar_ready", {31'd0, in_ready},  32'd0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    cyc(1'b1, 32'h100, 32'hF000_0100, 1'b0, 1'b0);
    chk("ar_accept", out_pc, 32'h100);
    cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("ar_drain", {30'd0, count}, 32'd0);

`ifdef IFID_BUBBLE_COUNT_EN
    reset = 1'b0;
    #1;
    reset = 1'b1;
    for (int i = 0; i < 5; i++) cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("bub_five", {16'd0, bubble_count}, 32'd5);
    force dut.bubble_cnt = 16'hFFFF;
    #1;
    release dut.bubble_cnt;
    cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("bub_sat", {16'd0, bubble_count}, 32'hFFFF);
`endif

    @(negedge clock);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
